// File: rtl/cla_pipe_adder_if.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder_if : operand/result bundle for the pipelined CLA adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic [WIDTH:0]   Q;
  logic             q_valid;
  logic             ovf;
  logic             zero;

  modport master (
    output load, A, B, Cin, sub,
    input  Q, q_valid, ovf, zero
  );

  modport slave (
    input  load, A, B, Cin, sub,
    output Q, q_valid, ovf, zero
  );
endinterface

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder : two-stage pipelined group-lookahead adder/subtractor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cla_pipe_adder_if.slave   io_bus
);

  localparam int c_NGRP = WIDTH / GROUP;

  if (WIDTH % GROUP != 0) begin : g_width_check
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  // Stage 1 combinational: operand conditioning, bit and group P/G
  logic [WIDTH-1:0]  w_bm;
  logic [WIDTH-1:0]  w_p;
  logic [WIDTH-1:0]  w_g;
  logic [c_NGRP-1:0] w_gp;
  logic [c_NGRP-1:0] w_gg;

  always_comb begin
    logic v_gen;
    v_gen = 1'b0;
    w_bm  = io_bus.sub ? ~io_bus.B : io_bus.B;
    w_p   = io_bus.A ^ w_bm;
    w_g   = io_bus.A & w_bm;
    w_gp  = '0;
    w_gg  = '0;
    for (int j = 0; j < c_NGRP; j++) begin
      w_gp[j] = &w_p[j*GROUP +: GROUP];
      v_gen   = 1'b0;
      for (int b = 0; b < GROUP; b++) begin
        v_gen = w_g[j*GROUP+b] | (w_p[j*GROUP+b] & v_gen);
      end
      w_gg[j] = v_gen;
    end
  end

  // Only the operand sign bits are needed beyond p/g for the overflow flag
  logic              r_v1;
  logic [WIDTH-1:0]  r_p;
  logic [WIDTH-1:0]  r_g;
  logic [c_NGRP-1:0] r_gp;
  logic [c_NGRP-1:0] r_gg;
  logic              r_cin;
  logic              r_a_msb;
  logic              r_bm_msb;

  // Stage 2 combinational: group carries, then in-group carries and sum
  logic [c_NGRP:0]   w_c;
  logic [WIDTH-1:0]  w_sum;
  logic              w_ovf;
  logic              w_zero;

  always_comb begin
    logic v_carry;
    v_carry = 1'b0;
    w_c     = '0;
    w_c[0]  = r_cin;
    for (int j = 0; j < c_NGRP; j++) begin
      w_c[j+1] = r_gg[j] | (r_gp[j] & w_c[j]);
    end
    w_sum = '0;
    for (int j = 0; j < c_NGRP; j++) begin
      v_carry = w_c[j];
      for (int b = 0; b < GROUP; b++) begin
        w_sum[j*GROUP+b] = r_p[j*GROUP+b] ^ v_carry;
        v_carry          = r_g[j*GROUP+b] | (r_p[j*GROUP+b] & v_carry);
      end
    end
    w_ovf  = (r_a_msb == r_bm_msb) && (w_sum[WIDTH-1] != r_a_msb);
    w_zero = (w_sum == '0);
  end

  logic [WIDTH:0] r_q;
  logic           r_q_valid;
  logic           r_ovf;
  logic           r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_p       <= '0;
      r_g       <= '0;
      r_gp      <= '0;
      r_gg      <= '0;
      r_cin     <= 1'b0;
      r_a_msb   <= 1'b0;
      r_bm_msb  <= 1'b0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_v1 <= io_bus.load;
      if (io_bus.load) begin
        r_p      <= w_p;
        r_g      <= w_g;
        r_gp     <= w_gp;
        r_gg     <= w_gg;
        r_cin    <= io_bus.Cin;
        r_a_msb  <= io_bus.A[WIDTH-1];
        r_bm_msb <= w_bm[WIDTH-1];
      end
      r_q_valid <= r_v1;
      if (r_v1) begin
        r_q    <= {w_c[c_NGRP], w_sum};
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign io_bus.Q       = r_q;
  assign io_bus.q_valid = r_q_valid;
  assign io_bus.ovf     = r_ovf;
  assign io_bus.zero    = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder : scoreboard bench, 16/4 and 8/2 instances side by side
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cla_pipe_adder;

  typedef struct packed {
    logic [16:0] q;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t sb16[$];
  exp_t sb8[$];
  exp_t last16 = '0;
  exp_t last8  = '0;
  exp_t e16;
  exp_t e8;

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(16)) io16 ();
  cla_pipe_adder_if #(.WIDTH(8))  io8  ();

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (.clk(clk), .rst(rst), .io_bus(io16));
  cla_pipe_adder #(.WIDTH(8),  .GROUP(2)) u_dut8  (.clk(clk), .rst(rst), .io_bus(io8));

  // Plain-arithmetic reference for a w-bit adder/subtractor
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    logic [31:0] mask, am, bm, s, low;
    exp_t r;
    mask   = (32'd1 << w) - 32'd1;
    am     = {16'd0, a} & mask;
    bm     = (sub ? ~{16'd0, b} : {16'd0, b}) & mask;
    s      = am + bm + {31'd0, cin};
    low    = s & mask;
    r.q    = s[16:0];
    r.zero = (low == 32'd0);
    r.ovf  = (am[w-1] == bm[w-1]) && (low[w-1] != am[w-1]);
    return r;
  endfunction

  function automatic exp_t mk(input logic [16:0] q, input logic ovf, input logic zero);
    exp_t r;
    r.q = q; r.ovf = ovf; r.zero = zero;
    return r;
  endfunction

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic op(input logic ld, input logic [15:0] a, input logic [15:0] b,
                    input logic cin, input logic sub, input exp_t e);
    @(negedge clk);
    io16.load = ld; io16.A = a;      io16.B = b;      io16.Cin = cin; io16.sub = sub;
    io8.load  = ld; io8.A  = a[7:0]; io8.B  = b[7:0]; io8.Cin  = cin; io8.sub  = sub;
    if (ld) begin
      sb16.push_back(e);
      sb8.push_back(model(8, a, b, cin, sub));
    end
  endtask

  task automatic rand_op(input logic ld);
    logic [15:0] a, b;
    logic        c, s;
    a = 16'($urandom); b = 16'($urandom);
    c = 1'($urandom);  s = 1'($urandom);
    op(ld, a, b, c, s, model(16, a, b, c, s));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, '0);
  endtask

  task automatic check_cleared(input string nm);
    check({nm, "_q"},     io16.Q,               17'd0);
    check({nm, "_valid"}, {16'd0, io16.q_valid}, 17'd0);
    check({nm, "_ovf"},   {16'd0, io16.ovf},     17'd0);
    check({nm, "_zero"},  {16'd0, io16.zero},    17'd0);
    check({nm, "_valid8"},{16'd0, io8.q_valid},  17'd0);
  endtask

  // Monitors: pop on valid, otherwise the outputs must hold the last result
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (io16.q_valid) begin
        if (sb16.size() == 0) begin
          check("unexpected_valid16", {16'd0, io16.q_valid}, 17'd0);
        end else begin
          e16 = sb16.pop_front();
          check("q16",    io16.Q,             e16.q);
          check("ovf16",  {16'd0, io16.ovf},  {16'd0, e16.ovf});
          check("zero16", {16'd0, io16.zero}, {16'd0, e16.zero});
          last16 = e16;
        end
      end else begin
        check("hold_q16", io16.Q, last16.q);
        check("hold_flags16", {15'd0, io16.ovf, io16.zero}, {15'd0, last16.ovf, last16.zero});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (io8.q_valid) begin
        if (sb8.size() == 0) begin
          check("unexpected_valid8", {16'd0, io8.q_valid}, 17'd0);
        end else begin
          e8 = sb8.pop_front();
          check("q8",     {8'd0, io8.Q},                e8.q);
          check("flags8", {15'd0, io8.ovf, io8.zero},   {15'd0, e8.ovf, e8.zero});
          last8 = e8;
        end
      end else begin
        check("hold8", {6'd0, io8.Q, io8.ovf, io8.zero}, {6'd0, last8.q[8:0], last8.ovf, last8.zero});
      end
    end
  end

  initial begin
    io16.load = 1'b0; io16.A = '0; io16.B = '0; io16.Cin = 1'b0; io16.sub = 1'b0;
    io8.load  = 1'b0; io8.A  = '0; io8.B  = '0; io8.Cin  = 1'b0; io8.sub  = 1'b0;

    // Reset held 3 cycles with load active and random operands
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      io16.load = 1'b1; io16.A = 16'($urandom); io16.B = 16'($urandom); io16.Cin = 1'b1;
      io8.load  = 1'b1; io8.A  = 8'($urandom);  io8.B  = 8'($urandom);  io8.Cin  = 1'b1;
      @(posedge clk); #2;
      check_cleared("reset");
    end
    @(negedge clk);
    rst = 1'b0; io16.load = 1'b0; io8.load = 1'b0;
    last16 = '0; last8 = '0;
    mon_en = 1'b1;
    @(posedge clk); #2;
    check_cleared("after_reset");

    // Directed vectors
    op(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, mk(17'h00100, 1'b0, 1'b0));
    idle(2);
    op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(17'h08000, 1'b1, 1'b0));
    op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, mk(17'h1FFFF, 1'b0, 1'b0));
    op(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, mk(17'h10000, 1'b1, 1'b1));
    op(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, mk(17'h0FFFE, 1'b0, 1'b0));
    op(1'b1, 16'h0007, 16'h0007, 1'b1, 1'b1, mk(17'h10000, 1'b0, 1'b1));
    idle(3);

    // Back-to-back issue, then a gap in which Q must hold
    op(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, mk(17'h00003, 1'b0, 1'b0));
    op(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, mk(17'h00007, 1'b0, 1'b0));
    op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(17'h10000, 1'b0, 1'b1));
    idle(4);
    @(posedge clk); #2;
    check("gap_q",     io16.Q,               17'h10000);
    check("gap_valid", {16'd0, io16.q_valid}, 17'd0);

    // Reset one cycle after a load: the operation must vanish
    op(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, mk(17'h03333, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1; io16.load = 1'b0; io8.load = 1'b0;
    sb16.delete(); sb8.delete();
    last16 = '0; last8 = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    check_cleared("midflight_k2");
    @(posedge clk); #2;
    check_cleared("midflight_k3");
    op(1'b1, 16'h1234, 16'h0001, 1'b0, 1'b0, mk(17'h01235, 1'b0, 1'b0));
    idle(3);

    // Random regression with random gaps; operands toggle during gaps too
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) rand_op(1'b0);
      rand_op(1'b1);
    end
    idle(1);

    for (int i = 0; i < 20 && (sb16.size() != 0 || sb8.size() != 0); i++) @(posedge clk);
    @(posedge clk); #2;
    check("drain16", 17'(sb16.size()), 17'd0);
    check("drain8",  17'(sb8.size()),  17'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
